// File: rtl/pll_clk_monitor.sv
// PLL supervisor in the refclk domain: sequences the PLL reset, qualifies lock,
// measures outclk_0 frequency per window and gates the downstream reset.
module pll_clk_monitor #(
  parameter int unsigned PLL_RST_CYC  = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned WINDOW       = 5000,
  parameter int unsigned EXP_EDGES    = 160,
  parameter int unsigned TOL          = 4
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        locked,
  input  logic        outclk_0,
  output logic        pll_rst,
  output logic        sys_rst_n,
  output logic        clk_ok,
  output logic [15:0] edge_count,
  output logic [7:0]  retry_cnt
);

  typedef enum logic [1:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_MEASURE,
    S_RUN
  } state_t;

  localparam logic [15:0] RST_LAST  = 16'(PLL_RST_CYC - 1);
  localparam logic [15:0] STAB_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] TO_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] WIN_LAST  = 16'(WINDOW - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Written as two one-sided bounds so no subtraction can underflow.
  function automatic logic in_tol(input logic [15:0] cnt);
    logic [31:0] c;
    c = {16'd0, cnt};
    return (c + TOL >= EXP_EDGES) && (c <= EXP_EDGES + TOL);
  endfunction

  logic lk_m_q, lk_s_q;
  logic oc_m_q, oc_s_q, oc_e_q;
  logic lk_s, rise;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] stab_q, stab_d;
  logic [15:0] win_q, win_d;
  logic [15:0] edges_q, edges_d;
  logic [15:0] edge_count_q, edge_count_d;
  logic [7:0]  retry_q, retry_d;
  logic        pll_rst_q, sys_rst_n_q, clk_ok_q;
  logic [15:0] edges_now;
  logic        restart;

  // Input synchronisers; outclk_0 is treated purely as data.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lk_m_q <= 1'b0;
      lk_s_q <= 1'b0;
      oc_m_q <= 1'b0;
      oc_s_q <= 1'b0;
      oc_e_q <= 1'b0;
    end else begin
      lk_m_q <= locked;
      lk_s_q <= lk_m_q;
      oc_m_q <= outclk_0;
      oc_s_q <= oc_m_q;
      oc_e_q <= oc_s_q;
    end
  end

  assign lk_s = lk_s_q;
  assign rise = oc_s_q & ~oc_e_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    stab_d       = stab_q;
    win_d        = win_q;
    edges_d      = edges_q;
    edge_count_d = edge_count_q;
    retry_d      = retry_q;
    restart      = 1'b0;
    edges_now    = rise ? sat_inc16(edges_q) : edges_q;

    case (state_q)
      S_RESET_PLL: begin
        if (timer_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      S_WAIT_LOCK: begin
        timer_d = timer_q + 16'd1;
        stab_d  = lk_s ? stab_q + 16'd1 : 16'd0;
        if (lk_s && (stab_q == STAB_LAST)) begin
          state_d = S_MEASURE;
          timer_d = 16'd0;
          stab_d  = 16'd0;
        end else if (timer_q == TO_LAST) begin
          restart = 1'b1;
        end
      end

      S_MEASURE, S_RUN: begin
        // Lock loss wins over a window ending on the same cycle.
        if (!lk_s) begin
          restart = 1'b1;
        end else if (win_q == WIN_LAST) begin
          edge_count_d = edges_now;
          win_d        = 16'd0;
          edges_d      = 16'd0;
          if (in_tol(edges_now)) begin
            state_d = S_RUN;
          end else begin
            restart = 1'b1;
          end
        end else begin
          win_d   = win_q + 16'd1;
          edges_d = edges_now;
        end
      end

      default: begin
        state_d = S_RESET_PLL;
        timer_d = 16'd0;
      end
    endcase

    if (restart) begin
      state_d = S_RESET_PLL;
      timer_d = 16'd0;
      stab_d  = 16'd0;
      win_d   = 16'd0;
      edges_d = 16'd0;
      retry_d = sat_inc8(retry_q);
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RESET_PLL;
      timer_q      <= 16'd0;
      stab_q       <= 16'd0;
      win_q        <= 16'd0;
      edges_q      <= 16'd0;
      edge_count_q <= 16'd0;
      retry_q      <= 8'd0;
      pll_rst_q    <= 1'b1;
      sys_rst_n_q  <= 1'b0;
      clk_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      stab_q       <= stab_d;
      win_q        <= win_d;
      edges_q      <= edges_d;
      edge_count_q <= edge_count_d;
      retry_q      <= retry_d;
      pll_rst_q    <= (state_d == S_RESET_PLL);
      sys_rst_n_q  <= (state_d == S_RUN);
      clk_ok_q     <= (state_d == S_RUN);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign clk_ok     = clk_ok_q;
  assign edge_count = edge_count_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Directed bench for pll_clk_monitor with a simple PLL lock model and a
// divided outclk_0 generator running off refclk.
module tb_pll_clk_monitor;

  localparam int WINDOW = 3200;

  logic        refclk = 1'b0;
  logic        rst = 1'b0;
  logic        locked;
  logic        outclk_0 = 1'b0;
  logic        pll_rst;
  logic        sys_rst_n;
  logic        clk_ok;
  logic [15:0] edge_count;
  logic [7:0]  retry_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int oc_half = 16;
  bit pll_auto = 1'b1;
  logic lock_man = 1'b0;
  logic lock_model = 1'b0;
  int lk_cnt = 0;

  assign locked = pll_auto ? lock_model : lock_man;

  pll_clk_monitor #(
    .PLL_RST_CYC (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(200),
    .WINDOW      (WINDOW),
    .EXP_EDGES   (100),
    .TOL         (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .outclk_0  (outclk_0),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .clk_ok    (clk_ok),
    .edge_count(edge_count),
    .retry_cnt (retry_cnt)
  );

  always #10 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  initial begin
    forever begin
      repeat (oc_half) @(negedge refclk);
      outclk_0 = ~outclk_0;
    end
  end

  // PLL model: lock comes up 10 refclk cycles after pll_rst falls.
  initial begin
    forever begin
      @(negedge refclk);
      if (pll_rst) begin
        lk_cnt = 0;
        lock_model = 1'b0;
      end else if (lk_cnt < 10) begin
        lk_cnt = lk_cnt + 1;
      end else begin
        lock_model = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic wait_pll(input logic lvl, input int bound, output bit ok);
    int n = 0;
    while (pll_rst !== lvl && n < bound) begin
      tick(1);
      n++;
    end
    ok = (pll_rst === lvl);
  endtask

  task automatic wait_ok(input int bound, output bit ok);
    int n = 0;
    while (clk_ok !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
    ok = (clk_ok === 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
    tests++; if (sys_rst_n !== 1'b0) begin fails++; $display("FAIL reset_sys_rst_n: got %b expected 0", sys_rst_n); end
    tests++; if (clk_ok !== 1'b0) begin fails++; $display("FAIL reset_clk_ok: got %b expected 0", clk_ok); end
    tests++; if (edge_count !== 16'd0) begin fails++; $display("FAIL reset_edge_count: got %0d expected 0", edge_count); end
    tests++; if (retry_cnt !== 8'd0) begin fails++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_nominal();
    int n = 0;
    bit ok;
    pll_auto = 1'b1;
    oc_half = 16;
    rst = 1'b1;
    while (pll_rst === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
    tests++; if (n != 4) begin fails++; $display("FAIL nominal_pll_rst_width: got %0d expected 4", n); end
    tests++; if (sys_rst_n !== 1'b0) begin fails++; $display("FAIL nominal_sys_rst_n_early: got %b expected 0", sys_rst_n); end
    wait_ok(5000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL nominal_run_timeout: clk_ok got %b expected 1", clk_ok); end
    tests++; if (sys_rst_n !== 1'b1) begin fails++; $display("FAIL nominal_sys_rst_n: got %b expected 1", sys_rst_n); end
    tests++; if (edge_count < 16'd99 || edge_count > 16'd101) begin fails++; $display("FAIL nominal_edge_count: got %0d expected 100+-1", edge_count); end
    tests++; if (retry_cnt !== 8'd0) begin fails++; $display("FAIL nominal_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_back_to_back();
    tick(2 * WINDOW + 17);
    tests++; if (clk_ok !== 1'b1) begin fails++; $display("FAIL b2b_clk_ok: got %b expected 1", clk_ok); end
    tests++; if (edge_count < 16'd99 || edge_count > 16'd101) begin fails++; $display("FAIL b2b_edge_count: got %0d expected 100+-1", edge_count); end
    tests++; if (retry_cnt !== 8'd0) begin fails++; $display("FAIL b2b_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_lock_loss();
    pll_auto = 1'b0;
    lock_man = 1'b0;
    tick(1);
    pll_auto = 1'b1;
    tests++; if (sys_rst_n !== 1'b1) begin fails++; $display("FAIL lockloss_edge1: sys_rst_n got %b expected 1", sys_rst_n); end
    tick(1);
    tests++; if (sys_rst_n !== 1'b1) begin fails++; $display("FAIL lockloss_edge2: sys_rst_n got %b expected 1", sys_rst_n); end
    tick(1);
    tests++; if (sys_rst_n !== 1'b0) begin fails++; $display("FAIL lockloss_edge3: sys_rst_n got %b expected 0", sys_rst_n); end
    tests++; if (clk_ok !== 1'b0) begin fails++; $display("FAIL lockloss_clk_ok: got %b expected 0", clk_ok); end
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL lockloss_pll_rst: got %b expected 1", pll_rst); end
    tests++; if (retry_cnt !== 8'd1) begin fails++; $display("FAIL lockloss_retry: got %0d expected 1", retry_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_ok(5000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL async_rerun_timeout: clk_ok got %b expected 1", clk_ok); end
    tick(1000);
    #4 rst = 1'b0;
    #1;
    tests++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || clk_ok !== 1'b0) begin
      fails++; $display("FAIL async_ctrl: got pll_rst=%b sys_rst_n=%b clk_ok=%b expected 1 0 0", pll_rst, sys_rst_n, clk_ok);
    end
    tests++; if (edge_count !== 16'd0 || retry_cnt !== 8'd0) begin
      fails++; $display("FAIL async_counts: got edge_count=%0d retry=%0d expected 0 0", edge_count, retry_cnt);
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL async_restart_pll_rst: got %b expected 1", pll_rst); end
    wait_ok(5000, ok);
    tests++; if (!ok || retry_cnt !== 8'd0) begin
      fails++; $display("FAIL async_rerun: got clk_ok=%b retry=%0d expected 1 0", clk_ok, retry_cnt);
    end
  endtask

  task automatic test_wrong_freq();
    int n = 0;
    bit seen_run = 1'b0;
    pll_auto = 1'b1;
    oc_half = 14;
    do_reset();
    while (retry_cnt === 8'd0 && n < 6000) begin
      if (sys_rst_n !== 1'b0 || clk_ok !== 1'b0) seen_run = 1'b1;
      tick(1);
      n++;
    end
    tests++; if (retry_cnt !== 8'd1) begin fails++; $display("FAIL wrongfreq_retry: got %0d expected 1", retry_cnt); end
    // 3200/28 = 114.3, so the window phase gives 114 or 115 rises.
    tests++; if (edge_count < 16'd114 || edge_count > 16'd115) begin fails++; $display("FAIL wrongfreq_edge_count: got %0d expected 114", edge_count); end
    tests++; if (seen_run || sys_rst_n !== 1'b0) begin fails++; $display("FAIL wrongfreq_sys_rst_n: got run=%b expected 0", seen_run); end
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL wrongfreq_pll_rst: got %b expected 1", pll_rst); end
    oc_half = 16;
  endtask

  task automatic test_glitchy_lock();
    bit ok;
    int t_fall;
    pll_auto = 1'b0;
    lock_man = 1'b0;
    do_reset();
    wait_pll(1'b0, 50, ok);
    t_fall = cyc;
    tick(3);
    lock_man = 1'b1; tick(5);
    lock_man = 1'b0; tick(3);
    lock_man = 1'b1; tick(5);
    lock_man = 1'b0;
    tests++; if (pll_rst !== 1'b0 || clk_ok !== 1'b0) begin
      fails++; $display("FAIL glitch_still_waiting: got pll_rst=%b clk_ok=%b expected 0 0", pll_rst, clk_ok);
    end
    wait_pll(1'b1, 400, ok);
    tests++; if (!ok || (cyc - t_fall) != 200) begin
      fails++; $display("FAIL glitch_timeout_len: got %0d expected 200", cyc - t_fall);
    end
    tests++; if (retry_cnt !== 8'd1) begin fails++; $display("FAIL glitch_retry: got %0d expected 1", retry_cnt); end
  endtask

  task automatic test_lock_timeout();
    bit ok;
    int t0;
    int n = 0;
    t0 = cyc;
    wait_pll(1'b0, 50, ok);
    tests++; if (!ok || (cyc - t0) != 4) begin fails++; $display("FAIL timeout_high_width: got %0d expected 4", cyc - t0); end
    t0 = cyc;
    wait_pll(1'b1, 400, ok);
    tests++; if (!ok || (cyc - t0) != 200) begin fails++; $display("FAIL timeout_low_width: got %0d expected 200", cyc - t0); end
    tests++; if (retry_cnt !== 8'd2) begin fails++; $display("FAIL timeout_retry2: got %0d expected 2", retry_cnt); end
    t0 = cyc;
    wait_pll(1'b0, 50, ok);
    wait_pll(1'b1, 400, ok);
    tests++; if (!ok || (cyc - t0) != 204 || retry_cnt !== 8'd3) begin
      fails++; $display("FAIL timeout_retry3: got period=%0d retry=%0d expected 204 3", cyc - t0, retry_cnt);
    end
    while (retry_cnt !== 8'hFF && n < 60000) begin
      tick(1);
      n++;
    end
    tests++; if (retry_cnt !== 8'hFF) begin fails++; $display("FAIL timeout_saturate: got %0d expected 255", retry_cnt); end
    tick(1000);
    tests++; if (retry_cnt !== 8'hFF) begin fails++; $display("FAIL timeout_hold: got %0d expected 255", retry_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_lock_loss();
    test_async_reset();
    test_wrong_freq();
    test_glitchy_lock();
    test_lock_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
